// File: rtl/dlx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dlx_pkg
// Brief    : Shared DLX constants and types used by fetch and decode.
// Revision : 1.0
// ============================================================================
package dlx_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0015;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_J       = 6'h02;
    localparam logic [5:0] c_OP_JAL     = 6'h03;
    localparam logic [5:0] c_OP_BEQZ    = 6'h04;
    localparam logic [5:0] c_OP_BNEZ    = 6'h05;
    localparam logic [5:0] c_OP_ADDI    = 6'h08;
    localparam logic [5:0] c_OP_LW      = 6'h23;
    localparam logic [5:0] c_OP_SW      = 6'h2B;
    localparam logic [5:0] c_FUNC_ADD   = 6'h20;

    // One fetched word together with its sequential successor address
    typedef struct packed {
        logic [0:31] instr;
        logic [31:0] pc_plus_four;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buf
// Brief    : Single-entry fetch buffer with write, pop and flush.
// Revision : 1.0
// ============================================================================
module fetch_buf
    import dlx_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         write,
    input  fetch_entry_t wdata,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output fetch_entry_t rdata
);

    logic         r_full;
    fetch_entry_t r_data;

    // Flush wins over a same-cycle write so a redirected response never lands
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_full <= 1'b0;
        end else if (write) begin
            r_full <= 1'b1;
        end else if (pop) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (write && !flush) begin
            r_data <= wdata;
        end
    end

    assign full  = r_full;
    assign rdata = r_data;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : DLX fetch stage: request FSM, fetch buffer and decode handoff.
// Revision : 1.0
// ============================================================================
module instr_fetch
    import dlx_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [0:31] imem_rdata,
    input  logic        stall,
    input  logic        kill_next_instruction,
    input  logic        branch,
    input  logic [31:0] new_pc_if_jump,
    output logic [0:31] instr,
    output logic [31:0] pc_plus_four,
    output logic        instr_valid,
    output logic        should_be_killed
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DROP = 2'd3;

    logic [1:0]   r_state;
    logic [31:0]  r_pc;
    logic         r_kill_pending;
    logic [0:31]  r_instr;
    logic [31:0]  r_pc_plus_four;
    logic         r_instr_valid;
    logic         r_should_be_killed;

    logic         w_buf_full;
    logic         w_buf_write;
    logic         w_buf_pop;
    fetch_entry_t w_buf_wdata;
    fetch_entry_t w_buf_rdata;

    // In WAIT the pc has already advanced past the issued address
    assign w_buf_wdata.instr        = imem_rdata;
    assign w_buf_wdata.pc_plus_four = r_pc;
    assign w_buf_write = (r_state == c_ST_WAIT) && imem_rvalid && !branch;
    assign w_buf_pop   = w_buf_full && !branch && !kill_next_instruction && !r_kill_pending;

    fetch_buf u_fetch_buf (
        .clk   (clk),
        .reset (reset),
        .write (w_buf_write),
        .wdata (w_buf_wdata),
        .pop   (w_buf_pop),
        .flush (branch),
        .full  (w_buf_full),
        .rdata (w_buf_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            if (branch) begin
                r_pc <= new_pc_if_jump;
            end else if ((r_state == c_ST_REQ) && imem_gnt) begin
                r_pc <= r_pc + 32'd4;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (!branch && !stall && !w_buf_full) begin
                        r_state <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (imem_gnt) begin
                        r_state <= branch ? c_ST_DROP : c_ST_WAIT;
                    end else if (branch) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_WAIT: begin
                    // A response coinciding with the branch is consumed here, not in DROP
                    if (branch) begin
                        r_state <= imem_rvalid ? c_ST_IDLE : c_ST_DROP;
                    end else if (imem_rvalid) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_DROP: begin
                    if (imem_rvalid) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // On a kill edge decode keeps its load; the buffered word is then shown once
    // as a bubble and replayed on the following edge before it is popped.
    always_ff @(posedge clk) begin
        if (reset || branch) begin
            r_instr            <= NOP_INSTR;
            r_pc_plus_four     <= 32'd0;
            r_instr_valid      <= 1'b0;
            r_should_be_killed <= 1'b0;
            r_kill_pending     <= 1'b0;
        end else if (kill_next_instruction) begin
            r_kill_pending <= 1'b1;
        end else if (w_buf_full) begin
            r_instr            <= w_buf_rdata.instr;
            r_pc_plus_four     <= w_buf_rdata.pc_plus_four;
            r_instr_valid      <= 1'b1;
            r_should_be_killed <= r_kill_pending;
            r_kill_pending     <= 1'b0;
        end else begin
            r_instr            <= NOP_INSTR;
            r_instr_valid      <= 1'b0;
            r_should_be_killed <= 1'b0;
        end
    end

    assign imem_req         = (r_state == c_ST_REQ);
    assign imem_addr        = r_pc;
    assign instr            = r_instr;
    assign pc_plus_four     = r_pc_plus_four;
    assign instr_valid      = r_instr_valid;
    assign should_be_killed = r_should_be_killed;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed self-checking bench for instr_fetch.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] c_NOP = 32'h0000_0015;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [0:31] imem_rdata;
    logic        stall;
    logic        kill_next_instruction;
    logic        branch;
    logic [31:0] new_pc_if_jump;
    logic [0:31] instr;
    logic [31:0] pc_plus_four;
    logic        instr_valid;
    logic        should_be_killed;

    int n_chk = 0;
    int n_err = 0;

    instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .imem_req              (imem_req),
        .imem_addr             (imem_addr),
        .imem_gnt              (imem_gnt),
        .imem_rvalid           (imem_rvalid),
        .imem_rdata            (imem_rdata),
        .stall                 (stall),
        .kill_next_instruction (kill_next_instruction),
        .branch                (branch),
        .new_pc_if_jump        (new_pc_if_jump),
        .instr                 (instr),
        .pc_plus_four          (pc_plus_four),
        .instr_valid           (instr_valid),
        .should_be_killed      (should_be_killed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 10 && imem_req !== 1'b1; i++) step();
        check(tag, {31'd0, imem_req}, 32'd1);
    endtask

    // Grant the pending request, then return the word one cycle later
    task automatic fetch_word(input logic [31:0] word);
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        step();
        imem_rvalid = 1'b0;
    endtask

    task automatic check_decode(input string tag, input logic [31:0] i, input logic [31:0] p4,
                                input logic v, input logic k);
        check({tag, "_instr"}, instr, i);
        check({tag, "_pc4"}, pc_plus_four, p4);
        check({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, v});
        check({tag, "_killed"}, {31'd0, should_be_killed}, {31'd0, k});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; kill_next_instruction = 1'b0; branch = 1'b0; new_pc_if_jump = '0;
        step();
        step();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h100);
        check_decode("rst", c_NOP, 32'd0, 1'b0, 1'b0);

        // First fetch after reset
        reset = 1'b0;
        wait_req("t1_req");
        check("t1_addr", imem_addr, 32'h100);
        fetch_word(32'h8C22_0004);
        step();
        check_decode("t1", 32'h8C22_0004, 32'h104, 1'b1, 1'b0);
        step();
        check("t1_empty_valid", {31'd0, instr_valid}, 32'd0);

        // Kill with a word buffered: bubble copy, then replay
        wait_req("t2_req");
        check("t2_addr", imem_addr, 32'h104);
        fetch_word(32'h0022_1820);
        kill_next_instruction = 1'b1;
        step();
        kill_next_instruction = 1'b0;
        step();
        check_decode("t2_bubble", 32'h0022_1820, 32'h108, 1'b1, 1'b1);
        step();
        check_decode("t2_replay", 32'h0022_1820, 32'h108, 1'b1, 1'b0);

        // Branch in WAIT, stale response two cycles later
        wait_req("t3_req");
        check("t3_addr", imem_addr, 32'h108);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; branch = 1'b1; new_pc_if_jump = 32'h400;
        step();
        branch = 1'b0;
        check_decode("t3_br", c_NOP, 32'd0, 1'b0, 1'b0);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check("t3_stale0", instr, c_NOP);
        step();
        check("t3_stale1", instr, c_NOP);
        check("t3_stale_valid", {31'd0, instr_valid}, 32'd0);
        check("t3_req", {31'd0, imem_req}, 32'd1);
        check("t3_target", imem_addr, 32'h400);

        // Branch and response in the same cycle
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        branch = 1'b1; new_pc_if_jump = 32'h800;
        step();
        imem_rvalid = 1'b0; branch = 1'b0;
        check_decode("t4_br", c_NOP, 32'd0, 1'b0, 1'b0);
        step();
        check("t4_instr", instr, c_NOP);
        check("t4_valid", {31'd0, instr_valid}, 32'd0);
        check("t4_req", {31'd0, imem_req}, 32'd1);
        check("t4_target", imem_addr, 32'h800);

        // Grant withheld: request and address stay stable
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_hold_req", {31'd0, imem_req}, 32'd1);
            check("t5_hold_addr", imem_addr, 32'h800);
        end
        fetch_word(32'h2001_0005);
        stall = 1'b1;
        step();
        check("t5_instr", instr, 32'h2001_0005);
        check("t5_pc4", pc_plus_four, 32'h804);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_stall_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        step();
        check("t5_req", {31'd0, imem_req}, 32'd1);
        check("t5_addr", imem_addr, 32'h804);

        // Kill with an empty buffer arms a pending bubble for the next word
        kill_next_instruction = 1'b1;
        step();
        kill_next_instruction = 1'b0;
        check("t6_req_kept", {31'd0, imem_req}, 32'd1);
        fetch_word(32'hAAAA_5555);
        check("t6_no_early", {31'd0, instr_valid}, 32'd0);
        step();
        check_decode("t6_bubble", 32'hAAAA_5555, 32'h808, 1'b1, 1'b1);
        step();
        check_decode("t6_replay", 32'hAAAA_5555, 32'h808, 1'b1, 1'b0);

        // Address wrap at the top of memory
        branch = 1'b1; new_pc_if_jump = 32'hFFFF_FFFC;
        step();
        branch = 1'b0;
        wait_req("t7_req");
        check("t7_addr", imem_addr, 32'hFFFF_FFFC);
        fetch_word(32'h1234_5678);
        step();
        check_decode("t7_wrap", 32'h1234_5678, 32'h0, 1'b1, 1'b0);
        wait_req("t7_req2");
        check("t7_addr2", imem_addr, 32'h0);

        // Reset mid-WAIT, then a stale response arriving in IDLE
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; reset = 1'b1;
        step();
        check("t8_req", {31'd0, imem_req}, 32'd0);
        check("t8_addr", imem_addr, 32'h100);
        check_decode("t8_rst", c_NOP, 32'd0, 1'b0, 1'b0);
        reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBADC_0DE0;
        step();
        imem_rvalid = 1'b0;
        check("t8_req_after", {31'd0, imem_req}, 32'd1);
        check("t8_addr_after", imem_addr, 32'h100);
        step();
        check("t8_stale_instr", instr, c_NOP);
        check("t8_stale_valid", {31'd0, instr_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The parameter list SHALL be: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 The port list SHALL be, one per line, name, direction, width, meaning; clock and reset come first:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  word address of request
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid; at most one per accepted request, earliest 1 cycle after gnt
- imem_rdata  in  [0:31]  instruction word, bit 0 = MSB
- stall  in  1  decode requests no new fetch issue this cycle
- kill_next_instruction  in  1  decode holds a load; next instruction must be bubbled then replayed
- branch  in  1  redirect taken (already gated by decode)
- new_pc_if_jump  in  32  redirect target
- instr  out  [0:31]  decode instruction register
- pc_plus_four  out  32  fetch address of instr + 4
- instr_valid  out  1  instr holds a real fetched word
- should_be_killed  out  1  instr is a bubble copy; decode must suppress side effects

Function
REQ-003 Fetch state machine: IDLE, REQ, WAIT, DROP.
REQ-004 IDLE: imem_req=0; go to REQ when the buffer is empty, stall=0 and branch=0.
REQ-005 REQ: imem_req=1, imem_addr=pc; imem_req and imem_addr SHALL hold stable until imem_gnt; on gnt: pc<=pc+4 (mod 2^32), go to WAIT.
REQ-006 WAIT: on imem_rvalid, write {imem_rdata, issued_pc+4} into the 1-entry fetch buffer; go to IDLE.
REQ-007 At most one request SHALL be outstanding; a request SHALL issue only when the buffer is empty.
REQ-008 Decode handoff on every edge, when not redirecting:
- buffer valid: load instr/pc_plus_four from the buffer; instr_valid=1.
- buffer empty: load NOP 32'h0000_0015; instr_valid=0; should_be_killed=0.
REQ-009 kill_next_instruction=1 at edge N: the word loaded at edge N+1 SHALL carry should_be_killed=1, and the buffer SHALL NOT pop; edge N+2 SHALL reload the same word with should_be_killed=0.
REQ-010 kill_next_instruction with an empty buffer SHALL arm a pending flag that applies to the next buffered word.
REQ-011 stall=1 SHALL block only a transition IDLE->REQ; REQ and WAIT are unaffected.
REQ-012 branch=1 SHALL have priority over kill and stall, and takes effect at the edge:
- pc<=new_pc_if_jump;
- buffer cleared; pending kill cleared;
- decode loaded with NOP, instr_valid=0, should_be_killed=0;
- REQ not yet granted: go to IDLE, with the request withdrawn at that edge;
- WAIT: go to DROP.
REQ-013 DROP: discard the next imem_rvalid; then go to IDLE. A branch in DROP SHALL only update pc.
REQ-014 Branch and imem_rvalid in the same cycle: the response SHALL be discarded.
REQ-015 pc_plus_four SHALL wrap: fetch at 32'hFFFF_FFFC yields 32'h0000_0000.

Reset
REQ-016 While reset=1: pc=RESET_PC, state IDLE, imem_req=0, buffer empty, pending kill cleared, instr=32'h0000_0015, pc_plus_four=0, instr_valid=0, should_be_killed=0.
REQ-017 Reset asserted mid-WAIT SHALL drop any later response; after reset the state machine SHALL start in IDLE, so a stale rvalid arriving in IDLE SHALL be ignored.

Structure
REQ-018 A shared package dlx_pkg SHALL hold NOP_INSTR (32'h0000_0015), the opcode constants, and DEFAULT_RESET_PC; decode and fetch SHALL both import it.
REQ-019 The fetch buffer SHALL be a sub-module fetch_buf (1 entry: write, pop, flush, full), and all other logic SHALL be in instr_fetch.
REQ-020 Target size is 150-300 lines of RTL.

Verification
REQ-021 Reset release, RESET_PC=0x100, gnt same cycle, rvalid 1 cycle later with 0x8C220004 -> imem_addr=0x100; the next handoff gives instr=0x8C220004, pc_plus_four=0x104, instr_valid=1.
REQ-022 Kill pulse with word 0x00221820 buffered -> the first handoff gives should_be_killed=1, the second gives the same word with should_be_killed=0 and pc_plus_four unchanged.
REQ-023 Branch to 0x400 while in WAIT, stale rvalid 0xDEADBEEF 2 cycles later -> 0xDEADBEEF never appears on instr; the next imem_addr is 0x400.
REQ-024 Branch and rvalid in the same cycle -> the response is discarded; decode shows NOP with instr_valid=0; the next request is at the target.
REQ-025 stall held 3 cycles with the state machine in IDLE -> imem_req=0 for those cycles; imem_gnt held low for 4 cycles while in REQ -> imem_addr stays constant.
REQ-026 pc=0xFFFFFFFC fetch -> pc_plus_four=0x00000000; reset asserted mid-WAIT -> all outputs at REQ-016 values on the next edge.
